// File: rtl/seg_scan_drv_pkg.sv
`default_nettype none
// ============================================================================
// seg_scan_drv_pkg
// Shared constants, FSM state encodings and pattern helpers for the 4-digit
// seven-segment scan driver.
// Revision: 1.0 - initial release
// ============================================================================
package seg_scan_drv_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_MINUS  = 7'b0111111;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Digit n occupies bits [7n+6:7n] of a packed frame.
  function automatic logic [6:0] digit_pat(input logic [27:0] frame,
                                           input logic [1:0]  idx);
    return frame[idx*7 +: 7];
  endfunction

  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_drv_scan_tick.sv
`default_nettype none
// ============================================================================
// scan_tick
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the last count.
// Revision: 1.0 - initial release
// ============================================================================
module scan_tick #(
  parameter int SCAN_DIV = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(SCAN_DIV)-1:0] cnt,
  output logic                        wrap
);

  localparam int              CW     = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   c_last = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign wrap = (r_cnt == c_last);
  assign cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_drv.sv
`default_nettype none
// ============================================================================
// seg_scan_drv
// Four-digit multiplexed seven-segment driver with a shadow frame that is
// committed only at frame boundaries, and blanking at the start of each slot.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_drv
  import seg_scan_drv_pkg::*;
#(
  parameter int SCAN_DIV  = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [27:0] seg_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        pending,
  output logic        frame_done
);

  localparam int            CW           = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] c_last_blank = CW'(BLANK_CYC - 1);
  localparam logic [1:0]    c_last_digit = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] w_cnt;
  logic          w_wrap;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_digit;
  logic [1:0]    w_digit_nxt;
  logic [27:0]   r_shadow;
  logic [27:0]   r_active;
  logic [27:0]   w_active_nxt;
  logic          w_commit;
  logic          r_pending;
  logic          w_pending_nxt;
  logic          r_frame_done;
  logic [6:0]    r_seg;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    r_an;
  logic [3:0]    w_an_nxt;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (w_cnt),
    .wrap (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are computed from next-cycle values so the registered drive
  // lines up with the registered state, digit and active frame.
  always_comb begin
    w_state_nxt   = r_state;
    w_digit_nxt   = r_digit;
    w_commit      = 1'b0;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_seg_nxt     = SEG_BLANK;
    w_an_nxt      = 4'b1111;

    case (r_state)
      BLANK:   if (w_cnt == c_last_blank) w_state_nxt = SHOW;
      SHOW:    if (w_wrap) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase

    if (w_wrap) begin
      w_digit_nxt = r_digit + 2'd1;
    end

    w_commit = w_wrap && (r_digit == c_last_digit) && r_pending;
    if (w_commit) begin
      w_active_nxt = r_shadow;
    end

    // A load on the commit edge keeps pending set for the new data.
    if (load) begin
      w_pending_nxt = 1'b1;
    end else if (w_commit) begin
      w_pending_nxt = 1'b0;
    end

    if ((w_state_nxt == SHOW) && en) begin
      w_seg_nxt = digit_pat(w_active_nxt, w_digit_nxt);
      w_an_nxt  = an_sel(w_digit_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit      <= 2'd0;
      r_shadow     <= {4{SEG_BLANK}};
      r_active     <= {4{SEG_BLANK}};
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_an         <= 4'b1111;
    end else begin
      r_digit      <= w_digit_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_frame_done <= w_commit;
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      if (load) begin
        r_shadow <= seg_in;
      end
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_drv.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_drv
// Self-checking bench: time-based reference model plus directed/random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_drv;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [27:0] seg_in = '0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        pending;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: t counts edges since reset; slot = (t/8)%4, phase = t%8.
  int          t = 0;
  logic [27:0] m_shadow = '1;
  logic [27:0] m_active = '1;
  logic        m_pend = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_commit;
  int          fd_cnt = 0;
  int          fd_t = 0;
  int          m_dig;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;

  seg_scan_drv #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  always @(posedge clk) begin
    logic en_s;
    en_s = en;
    if (rst) begin
      t        = 0;
      m_shadow = '1;
      m_active = '1;
      m_pend   = 1'b0;
      m_fd     = 1'b0;
      en_s     = 1'b0;
    end else begin
      m_commit = (((t + 1) % 32) == 0) && m_pend;
      if (m_commit) m_active = m_shadow;
      if (load) begin
        m_shadow = seg_in;
        m_pend   = 1'b1;
      end else if (m_commit) begin
        m_pend = 1'b0;
      end
      m_fd = m_commit;
      t++;
    end
    m_dig = (t / 8) % 4;
    if (en_s && ((t % 8) >= 2)) begin
      m_seg = m_active[m_dig*7 +: 7];
      m_an  = 4'b1111 & ~(4'b0001 << m_dig);
    end else begin
      m_seg = 7'h7f;
      m_an  = 4'hf;
    end
    #1;
    check("seg_out", 32'(seg_out), 32'(m_seg));
    check("an_out", 32'(an_out), 32'(m_an));
    check("pending", 32'(pending), 32'(m_pend));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_t = t;
    end
  end

  task automatic wait_mod(input int v);
    for (int i = 0; i < 64; i++) begin
      if ((t % 32) == v) return;
      @(negedge clk);
    end
    check("wait_mod_timeout", 32'(t % 32), 32'(v));
  endtask

  task automatic load_word(input logic [27:0] w);
    load   = 1'b1;
    seg_in = w;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    logic [27:0] pat_a, pat_c, pat_d, pat_e;
    int          t_prev;
    bit          got;
    pat_a = {7'h06, 7'h5B, 7'h4F, SEG_MINUS};
    pat_c = {7'h79, 7'h24, 7'h30, 7'h19};
    pat_d = {7'h12, 7'h02, 7'h78, 7'h00};
    pat_e = {7'h10, 7'h08, 7'h03, 7'h46};

    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'h7f);
    check("rst_an", 32'(an_out), 32'hf);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Idle frame: no frame_done without a load.
    fd_cnt = 0;
    repeat (32) @(negedge clk);
    check("idle_fd_count", 32'(fd_cnt), 32'h0);

    // Basic load and commit.
    load_word(pat_a);
    check("load_pending", 32'(pending), 32'h1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (frame_done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check("fd_seen", 32'(got), 32'h1);
    check("fd_phase", 32'(t % 32), 32'h0);
    repeat (2) @(negedge clk);
    check("d0_seg", 32'(seg_out), 32'h3f);
    check("d0_an", 32'(an_out), 32'he);
    repeat (24) @(negedge clk);
    check("d3_seg", 32'(seg_out), 32'h06);
    check("d3_an", 32'(an_out), 32'h7);

    // Two loads in one frame: only the later one shows.
    wait_mod(9);
    load_word({7'h11, 7'h22, 7'h33, 7'h44});
    wait_mod(17);
    load_word(pat_c);
    fd_cnt = 0;
    wait_mod(2);
    check("overwrite_fd_count", 32'(fd_cnt), 32'h1);
    check("overwrite_seg", 32'(seg_out), 32'h19);
    check("overwrite_an", 32'(an_out), 32'he);

    // Load on the commit edge.
    wait_mod(5);
    load_word(pat_d);
    wait_mod(31);
    load_word(pat_e);
    check("coinc_pending", 32'(pending), 32'h1);
    check("coinc_fd", 32'(frame_done), 32'h1);
    t_prev = t;
    fd_cnt = 0;
    repeat (2) @(negedge clk);
    check("coinc_prev_seg", 32'(seg_out), 32'h00);
    repeat (32) @(negedge clk);
    check("coinc_fd_count", 32'(fd_cnt), 32'h1);
    check("coinc_fd_gap", 32'(fd_t - t_prev), 32'd32);
    check("coinc_new_seg", 32'(seg_out), 32'h46);

    // Display disable during SHOW.
    wait_mod(4);
    en = 1'b0;
    @(negedge clk);
    check("en0_seg", 32'(seg_out), 32'h7f);
    check("en0_an", 32'(an_out), 32'hf);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_mod(10);
    check("en1_seg", 32'(seg_out), 32'h03);
    check("en1_an", 32'(an_out), 32'hd);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom_range(0, 7) == 0);
      seg_in = 28'($urandom);
      en     = ($urandom_range(0, 4) != 0);
      @(negedge clk);
    end
    load = 1'b0;
    en   = 1'b1;

    // Asynchronous reset mid-SHOW of digit 2 with pending data.
    wait_mod(20);
    load_word(pat_a);
    #2;
    rst = 1'b1;
    #1;
    check("arst_seg", 32'(seg_out), 32'h7f);
    check("arst_an", 32'(an_out), 32'hf);
    check("arst_pending", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_phase", 32'(t), 32'd1);
    check("post_rst_an", 32'(an_out), 32'hf);
    check("post_rst_pending", 32'(pending), 32'h0);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SCAN_DIV, default 8, clock cycles per digit slot; the block SHALL support SCAN_DIV in 3..65535.
REQ-002 BLANK_CYC, default 2, leading blank cycles per slot; the block SHALL support 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 clk  in  1  single system clock; every register SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 en  in  1  display enable; 0 SHALL force both outputs blank while scanning continues.
REQ-006 load  in  1  one-cycle write strobe for seg_in.
REQ-007 seg_in  in  28  four active-low gfedcba patterns: [6:0] is digit 0 and [27:21] is digit 3; sign-digit patterns come from the negative-sign decoder.
REQ-008 seg_out  out  7  active-low gfedcba segment drive.
REQ-009 an_out  out  4  active-low one-hot digit select; bit n selects digit n.
REQ-010 pending  out  1  high when the shadow holds data not yet shown.
REQ-011 frame_done  out  1  one-cycle pulse when the shadow is committed to the active registers.

Function
REQ-012 Internal storage SHALL be a 28-bit shadow register, a 28-bit active register, a 2-bit digit index, a slot counter of width clog2(SCAN_DIV), and a two-state FSM with states BLANK and SHOW.
REQ-013 Slot counter SHALL count 0..SCAN_DIV-1 and then wrap to 0.
- At each wrap the digit index SHALL increment modulo 4 (3 -> 0).
REQ-014 FSM SHALL be BLANK while the counter is 0..BLANK_CYC-1 and SHOW while it is BLANK_CYC..SCAN_DIV-1.
- BLANK -> SHOW when the counter reaches BLANK_CYC.
- SHOW -> BLANK at counter wrap.
REQ-015 In BLANK, or when en=0, the outputs SHALL be seg_out=7'b1111111 and an_out=4'b1111.
REQ-016 In SHOW with en=1, the outputs SHALL be:
- seg_out = the active pattern of the current digit;
- an_out = ~(4'b0001 << digit).
REQ-017 All outputs SHALL be registered and SHALL be glitch-free.
REQ-018 load=1 SHALL capture seg_in into the shadow and set pending on the next edge.
- load has no busy or backpressure; a later load overwrites an uncommitted shadow.
REQ-019 Commit SHALL occur only on the transition from digit 3 to digit 0 (frame boundary) with pending=1.
- Commit copies the shadow to the active register, clears pending, and pulses frame_done.
- frame_done SHALL be high during the first BLANK cycle of digit 0.
REQ-020 A commit SHALL NOT occur mid-frame; partially refreshed frames are forbidden.
REQ-021 load coinciding with a commit edge:
- the commit SHALL use the previous shadow;
- the new data SHALL enter the shadow;
- pending SHALL remain 1 and frame_done SHALL still pulse.
REQ-022 Latency from load to first display of the new data SHALL be 1..(4*SCAN_DIV + BLANK_CYC + 1) cycles.
REQ-023 en SHALL NOT affect the counter, the digit index, the shadow, pending, or commit timing.

Reset
REQ-024 While rst=1 the block SHALL hold:
- shadow and active = all 7'b1111111;
- digit = 0, counter = 0, state = BLANK;
- pending = 0, frame_done = 0;
- seg_out = 7'b1111111, an_out = 4'b1111.
REQ-025 Reset asserted mid-frame or mid-load SHALL discard shadow data immediately, without waiting for a clock edge.
REQ-026 After rst deasserts, the first clock edge SHALL begin the digit-0 BLANK slot at counter 0.

Structure
REQ-027 A shared include file SHALL define:
- SEG_BLANK = 7'b1111111 and SEG_MINUS = 7'b0111111;
- the FSM state encodings BLANK and SHOW;
- the digit count 4.
REQ-028 The prescaler SHALL be a sub-module named scan_tick.
- scan_tick outputs the counter value and a wrap strobe.
- The FSM, the registers and the output logic stay in seg_scan_drv.

Verification
REQ-029 The bench SHALL run with SCAN_DIV=8 and BLANK_CYC=2; each case is stimulus -> required response.
- Reset, then 32 idle cycles with en=1 -> an_out=4'b1111 or a one-hot-low pattern, seg_out=7'b1111111 throughout, frame_done never pulses.
- load seg_in={7'h06,7'h5B,7'h4F,SEG_MINUS} -> pending=1; frame_done at the next frame boundary; the following digit-0 SHOW cycles give seg_out=7'b0111111, an_out=4'b1110; digit 3 gives 7'h06 with an_out=4'b0111.
- load in digit 1, then a second load in digit 2 -> only the second value is displayed; exactly one frame_done.
- load on the commit edge -> the previous shadow is displayed; pending stays 1; a second frame_done one frame (32 cycles) later.
- en=0 during SHOW -> outputs blank on the next edge; counter and index unaffected; frame_done timing unchanged.
- rst pulsed mid-SHOW of digit 2 -> outputs blank with no clock edge; after release, digit 0 BLANK; pending=0.
